// File: rtl/bram_rd_arbiter_if.sv
// Requester-side and BRAM-side signals of the shared BRAM read port arbiter.
// slave: the arbiter itself; master: whatever drives requests and models the BRAM.
interface bram_rd_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        i_req_trig;
  logic [N_REQ*ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0]       o_req_data;
  logic [N_REQ-1:0]        o_req_done;
  logic                    o_req_err;
  logic [ADDR_W-1:0]       o_bram_addr;
  logic                    o_bram_trig;
  logic [DATA_W-1:0]       i_bram_data;
  logic                    i_bram_done;
  logic                    o_busy;
  logic [7:0]              debug_port;

  modport slave (
    input  i_req_trig, i_req_addr, i_bram_data, i_bram_done,
    output o_req_data, o_req_done, o_req_err, o_bram_addr, o_bram_trig, o_busy, debug_port
  );

  modport master (
    output i_req_trig, i_req_addr, i_bram_data, i_bram_done,
    input  o_req_data, o_req_done, o_req_err, o_bram_addr, o_bram_trig, o_busy, debug_port
  );
endinterface

// File: rtl/bram_rd_arbiter.sv
// Round-robin share of one BRAM read port among N_REQ level-held readers, with a read watchdog.
// Grant one edge after request, done one edge after i_bram_done; requesters hold trig until their done.
module bram_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  bram_rd_arbiter_if.slave bus
);
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);
  localparam logic [2:0]        LAST_RST = 3'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

  state_t            state;
  logic [2:0]        grant;
  logic [2:0]        last_grant;
  logic [N_REQ-1:0]  blocked;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  fin_mask;
  logic [CNT_W-1:0]  wd_cnt;
  logic              fin;
  logic              pick_vld;
  logic [2:0]        pick_idx;
  logic [ADDR_W-1:0] pick_addr;
  int                best;
  int                off;

  assign eligible       = bus.i_req_trig & ~blocked;
  assign fin            = (state == BUSY) && (bus.i_bram_done || (wd_cnt == WD_LAST));
  assign fin_mask       = fin ? (ONE_HOT0 << grant) : '0;
  assign bus.o_busy     = (state == BUSY);
  assign bus.debug_port = {grant, 3'b000, state};

  // Distance 0 is the slot right after last_grant; the smallest eligible distance wins.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_addr = '0;
    best      = N_REQ;
    off       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + 2 * N_REQ - 1 - int'(last_grant)) % N_REQ;
      if (eligible[i] && (off < best)) begin
        best      = off;
        pick_vld  = 1'b1;
        pick_idx  = 3'(i);
        pick_addr = bus.i_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state           <= IDLE;
      grant           <= '0;
      last_grant      <= LAST_RST;
      blocked         <= '0;
      wd_cnt          <= '0;
      bus.o_bram_trig <= 1'b0;
      bus.o_bram_addr <= '0;
      bus.o_req_data  <= '0;
      bus.o_req_done  <= '0;
      bus.o_req_err   <= 1'b0;
    end else begin
      // A finishing requester stays blocked until its trig is seen low; setting beats clearing.
      blocked <= fin_mask | (blocked & bus.i_req_trig);
      case (state)
        BUSY: begin
          if (bus.i_bram_done) begin
            bus.o_req_data  <= bus.i_bram_data;
            bus.o_req_done  <= fin_mask;
            bus.o_req_err   <= 1'b0;
            bus.o_bram_trig <= 1'b0;
            state           <= GAP;
          end else if (wd_cnt == WD_LAST) begin
            bus.o_req_data  <= '0;
            bus.o_req_done  <= fin_mask;
            bus.o_req_err   <= 1'b1;
            bus.o_bram_trig <= 1'b0;
            state           <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          bus.o_req_done <= '0;
          bus.o_req_err  <= 1'b0;
          if (pick_vld) begin
            grant           <= pick_idx;
            last_grant      <= pick_idx;
            bus.o_bram_addr <= pick_addr;
            bus.o_bram_trig <= 1'b1;
            wd_cnt          <= '0;
            state           <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter (TIMEOUT=8); inputs driven and outputs sampled on negedge.
module tb_bram_rd_arbiter;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  bram_rd_arbiter_if #(.N_REQ(4), .ADDR_W(13), .DATA_W(32)) bus ();

  bram_rd_arbiter #(.N_REQ(4), .ADDR_W(13), .DATA_W(32), .TIMEOUT(8)) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic t, input logic [12:0] a);
    bus.i_req_trig[i]          = t;
    bus.i_req_addr[i*13 +: 13] = a;
  endtask

  task automatic drain();
    bus.i_req_trig  = '0;
    bus.i_bram_data = '0;
    bus.i_bram_done = 1'b1;
    tick(1);
    bus.i_bram_done = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    bus.i_req_trig  = '0;
    bus.i_req_addr  = '0;
    bus.i_bram_data = '0;
    bus.i_bram_done = 1'b0;
    tick(2);
    checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL reset_trig got=%0h exp=0", bus.o_bram_trig); end
    checks++; if (bus.o_bram_addr !== 13'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.o_bram_addr); end
    checks++; if (bus.o_req_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.o_req_data); end
    checks++; if (bus.o_req_done !== 4'h0) begin failures++; $display("FAIL reset_done got=%0h exp=0", bus.o_req_done); end
    checks++; if (bus.o_req_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.o_req_err); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.o_busy); end
    checks++; if (bus.debug_port !== 8'h00) begin failures++; $display("FAIL reset_debug got=%0h exp=0", bus.debug_port); end
    rstn = 1'b1;
    tick(1);
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%0h exp=0", bus.o_busy); end
  endtask

  task automatic test_single_read();
    set_req(2, 1'b1, 13'h0A5);
    tick(1);
    checks++; if (bus.o_bram_trig !== 1'b1) begin failures++; $display("FAIL single_trig got=%0h exp=1", bus.o_bram_trig); end
    checks++; if (bus.o_bram_addr !== 13'h0A5) begin failures++; $display("FAIL single_addr got=%0h exp=0a5", bus.o_bram_addr); end
    checks++; if (bus.debug_port !== 8'h41) begin failures++; $display("FAIL single_debug_busy got=%0h exp=41", bus.debug_port); end
    tick(2);
    checks++; if (bus.o_req_done !== 4'h0) begin failures++; $display("FAIL single_early_done got=%0h exp=0", bus.o_req_done); end
    bus.i_bram_done = 1'b1;
    bus.i_bram_data = 32'hDEADBEEF;
    tick(1);
    bus.i_bram_done = 1'b0;
    bus.i_bram_data = 32'h11111111;
    checks++; if (bus.o_req_done !== 4'b0100) begin failures++; $display("FAIL single_done got=%0h exp=4", bus.o_req_done); end
    checks++; if (bus.o_req_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%0h exp=deadbeef", bus.o_req_data); end
    checks++; if (bus.o_req_err !== 1'b0) begin failures++; $display("FAIL single_err got=%0h exp=0", bus.o_req_err); end
    checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL single_trig_low got=%0h exp=0", bus.o_bram_trig); end
    set_req(2, 1'b0, 13'h0A5);
    tick(1);
    checks++; if (bus.o_req_done !== 4'h0) begin failures++; $display("FAIL single_done_one_cycle got=%0h exp=0", bus.o_req_done); end
    checks++; if (bus.o_req_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data_hold got=%0h exp=deadbeef", bus.o_req_data); end
    checks++; if (bus.debug_port !== 8'h40) begin failures++; $display("FAIL single_debug_idle got=%0h exp=40", bus.debug_port); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_done;
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 13'h100 + 13'(i));
    tick(1);
    for (int k = 0; k < 8; k++) begin
      exp_done = 4'b0001 << (k % 4);
      checks++; if (bus.o_bram_trig !== 1'b1) begin failures++; $display("FAIL contend_trig[%0d] got=%0h exp=1", k, bus.o_bram_trig); end
      checks++; if (bus.o_bram_addr !== 13'h100 + 13'(k % 4)) begin failures++; $display("FAIL contend_addr[%0d] got=%0h exp=%0h", k, bus.o_bram_addr, 13'h100 + 13'(k % 4)); end
      tick(1);
      bus.i_bram_done = 1'b1;
      bus.i_bram_data = 32'hC0DE0000 + 32'(k);
      tick(1);
      bus.i_bram_done = 1'b0;
      checks++; if (bus.o_req_done !== exp_done) begin failures++; $display("FAIL contend_done[%0d] got=%0h exp=%0h", k, bus.o_req_done, exp_done); end
      checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL contend_gap[%0d] got=%0h exp=0", k, bus.o_bram_trig); end
      checks++; if (bus.o_req_data !== 32'hC0DE0000 + 32'(k)) begin failures++; $display("FAIL contend_data[%0d] got=%0h exp=%0h", k, bus.o_req_data, 32'hC0DE0000 + 32'(k)); end
      bus.i_req_trig[k % 4] = 1'b0;
      tick(1);
      bus.i_req_trig[k % 4] = 1'b1;
    end
    drain();
  endtask

  task automatic test_held_trig();
    set_req(1, 1'b1, 13'h055);
    tick(1);
    checks++; if (bus.o_bram_addr !== 13'h055) begin failures++; $display("FAIL held_addr got=%0h exp=055", bus.o_bram_addr); end
    tick(1);
    bus.i_bram_done = 1'b1;
    bus.i_bram_data = 32'h12345678;
    tick(1);
    bus.i_bram_done = 1'b0;
    checks++; if (bus.o_req_done !== 4'b0010) begin failures++; $display("FAIL held_done got=%0h exp=2", bus.o_req_done); end
    for (int c = 0; c < 5; c++) begin
      tick(1);
      checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL held_no_regrant[%0d] got=%0h exp=0", c, bus.o_bram_trig); end
    end
    set_req(1, 1'b0, 13'h055);
    tick(1);
    checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL held_low_trig got=%0h exp=0", bus.o_bram_trig); end
    set_req(1, 1'b1, 13'h055);
    tick(1);
    checks++; if (bus.o_bram_trig !== 1'b1) begin failures++; $display("FAIL held_regrant got=%0h exp=1", bus.o_bram_trig); end
    tick(1);
    bus.i_bram_done = 1'b1;
    bus.i_bram_data = 32'h0BADCAFE;
    tick(1);
    bus.i_bram_done = 1'b0;
    set_req(1, 1'b0, 13'h055);
    checks++; if (bus.o_req_data !== 32'h0BADCAFE) begin failures++; $display("FAIL held_data2 got=%0h exp=0badcafe", bus.o_req_data); end
    tick(1);
  endtask

  task automatic test_timeout();
    set_req(3, 1'b1, 13'h1FF);
    tick(1);
    checks++; if (bus.o_bram_trig !== 1'b1) begin failures++; $display("FAIL tmo_trig got=%0h exp=1", bus.o_bram_trig); end
    for (int c = 1; c < 8; c++) begin
      tick(1);
      checks++; if (bus.o_req_done !== 4'h0) begin failures++; $display("FAIL tmo_early[%0d] got=%0h exp=0", c, bus.o_req_done); end
    end
    tick(1);
    checks++; if (bus.o_req_done !== 4'b1000) begin failures++; $display("FAIL tmo_done got=%0h exp=8", bus.o_req_done); end
    checks++; if (bus.o_req_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0h exp=1", bus.o_req_err); end
    checks++; if (bus.o_req_data !== 32'h0) begin failures++; $display("FAIL tmo_data got=%0h exp=0", bus.o_req_data); end
    checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL tmo_trig_low got=%0h exp=0", bus.o_bram_trig); end
    set_req(3, 1'b0, 13'h1FF);
    tick(1);
    checks++; if (bus.o_req_err !== 1'b0) begin failures++; $display("FAIL tmo_err_clear got=%0h exp=0", bus.o_req_err); end
    set_req(3, 1'b1, 13'h1FF);
    tick(1);
    tick(7);
    bus.i_bram_done = 1'b1;
    bus.i_bram_data = 32'h600D0D0E;
    tick(1);
    bus.i_bram_done = 1'b0;
    checks++; if (bus.o_req_done !== 4'b1000) begin failures++; $display("FAIL tie_done got=%0h exp=8", bus.o_req_done); end
    checks++; if (bus.o_req_err !== 1'b0) begin failures++; $display("FAIL tie_err got=%0h exp=0", bus.o_req_err); end
    checks++; if (bus.o_req_data !== 32'h600D0D0E) begin failures++; $display("FAIL tie_data got=%0h exp=600d0d0e", bus.o_req_data); end
    set_req(3, 1'b0, 13'h1FF);
    tick(1);
  endtask

  task automatic test_reset_mid_read();
    set_req(0, 1'b1, 13'h0AA);
    tick(1);
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%0h exp=1", bus.o_busy); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.o_bram_trig !== 1'b0) begin failures++; $display("FAIL rmid_trig got=%0h exp=0", bus.o_bram_trig); end
    checks++; if (bus.o_bram_addr !== 13'h0) begin failures++; $display("FAIL rmid_addr got=%0h exp=0", bus.o_bram_addr); end
    checks++; if (bus.debug_port !== 8'h00) begin failures++; $display("FAIL rmid_debug got=%0h exp=0", bus.debug_port); end
    set_req(3, 1'b1, 13'h1E3);
    tick(1);
    rstn = 1'b1;
    tick(1);
    checks++; if (bus.o_bram_addr !== 13'h0AA) begin failures++; $display("FAIL rmid_prio_addr got=%0h exp=0aa", bus.o_bram_addr); end
    checks++; if (bus.debug_port !== 8'h01) begin failures++; $display("FAIL rmid_prio_debug got=%0h exp=01", bus.debug_port); end
    drain();
  endtask

  task automatic test_abandoned();
    set_req(0, 1'b1, 13'h0F0);
    tick(1);
    checks++; if (bus.o_bram_addr !== 13'h0F0) begin failures++; $display("FAIL aband_addr got=%0h exp=0f0", bus.o_bram_addr); end
    set_req(0, 1'b0, 13'h0F0);
    tick(1);
    checks++; if (bus.o_bram_trig !== 1'b1) begin failures++; $display("FAIL aband_hold got=%0h exp=1", bus.o_bram_trig); end
    bus.i_bram_done = 1'b1;
    bus.i_bram_data = 32'hCAFEF00D;
    tick(1);
    bus.i_bram_done = 1'b0;
    checks++; if (bus.o_req_done !== 4'b0001) begin failures++; $display("FAIL aband_done got=%0h exp=1", bus.o_req_done); end
    checks++; if (bus.o_req_data !== 32'hCAFEF00D) begin failures++; $display("FAIL aband_data got=%0h exp=cafef00d", bus.o_req_data); end
    tick(1);
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL aband_idle got=%0h exp=0", bus.o_busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_held_trig();
    test_timeout();
    test_reset_mid_read();
    test_abandoned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Round-robin arbiter that shares the single top-level BRAM read port (13-bit word address, 32-bit data, trig/done handshake) among up to N_REQ readers, such as several row-fetch engines feeding the connected-domain filter. It serialises one 32-bit read at a time and returns data and a one-cycle done to the granted requester. A watchdog aborts reads that never complete.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ADDR_W, 13: BRAM word address width.
- DATA_W, 32: BRAM data width.
- TIMEOUT, 64: maximum cycles in BUSY before the read is aborted (≥2).
- i_clk  in  1  the single clock; all logic on rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_req_trig  in  N_REQ  per-requester read request, level; held until its done.
- i_req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]; stable while its trig is high.
- o_req_data  out  DATA_W  shared read data; valid only in the cycle o_req_done is nonzero.
- o_req_done  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- o_req_err  out  1  high with o_req_done when the read timed out.
- o_bram_addr  out  ADDR_W  address to the BRAM read controller.
- o_bram_trig  out  1  read request to the BRAM read controller.
- i_bram_data  in  DATA_W  BRAM read data, valid with i_bram_done.
- i_bram_done  in  1  BRAM read complete, one-cycle pulse.
- o_busy  out  1  high in BUSY.
- debug_port  out  8  {grant index[2:0], 3'b0, state[1:0]}.

## Operation
- States: IDLE=0, BUSY=1, GAP=2.
- eligible[i] = i_req_trig[i] & ~blocked[i]. blocked[i] is set on the edge that completes requester i's read and cleared on any edge where i_req_trig[i]==0. If both apply on the same edge, set wins.
- Arbitration happens in IDLE and GAP. The search starts at index (last_grant+1) mod N_REQ and picks the first eligible index. After reset, last_grant = N_REQ-1, so requester 0 has top priority.
- On grant: latch the index and that requester's address into o_bram_addr, set o_bram_trig=1, update last_grant, clear the watchdog counter, and go to BUSY.
- BUSY: hold o_bram_trig and o_bram_addr. Ignore requester-side changes, including trig being withdrawn; the read still completes.
  - On i_bram_done: o_req_data←i_bram_data, o_req_done[g]←1, o_req_err←0, o_bram_trig←0, blocked[g]←1, go to GAP.
  - If the counter reaches TIMEOUT-1 without done: o_req_data←0, o_req_done[g]←1, o_req_err←1, o_bram_trig←0, blocked[g]←1, go to GAP.
- GAP: clear o_req_done and o_req_err (o_req_data holds its value). If any requester is eligible, grant it and go to BUSY; otherwise go to IDLE.
- A late i_bram_done arriving in IDLE or GAP is ignored.
- Reset (asynchronous, any state): state IDLE. All outputs are 0: o_bram_trig, o_bram_addr, o_req_data, o_req_done, o_req_err, o_busy, debug_port. Also blocked=0, last_grant=N_REQ-1, counter=0.

## Timing
- Edge E0 samples an eligible request in IDLE. o_bram_trig rises after E0.
- Edge Ed samples i_bram_done. o_req_done and o_req_data are valid in the cycle after Ed, and o_bram_trig is low in that same cycle.
- Request-to-done latency = BRAM latency + 1 cycle.
- Back-to-back grants: o_bram_trig is low for exactly one cycle (GAP) between reads.
- The requester that just finished cannot be regranted until its trig has been seen low for at least one edge.
- Timeout: the error done appears TIMEOUT cycles after o_bram_trig rose.
- Simultaneous events:
  - Requests in IDLE/GAP: round-robin order decides.
  - i_bram_done and the timeout on the same edge: done wins, and o_req_err=0.

## Test plan
- Single read: requester 2 raises trig with addr=13'h0A5, and the BRAM returns 32'hDEADBEEF after 3 cycles. Expect o_bram_addr=0A5, o_req_done=4'b0100 for one cycle, o_req_data=DEADBEEF, o_req_err=0.
- Contention: all four requesters hold trig continuously (re-raised after each done). Expect grants in order 0,1,2,3,0,… and exactly one GAP cycle of o_bram_trig=0 between reads.
- Held trig: requester 1 keeps trig high for 5 cycles after its done while no one else requests. Expect no new grant until trig has been low for one edge, then a fresh grant.
- Timeout: with TIMEOUT=8 the BRAM never returns done. Expect o_req_done[g]=1, o_req_err=1, o_req_data=0 eight cycles after the trig rise, then o_bram_trig=0.
- Reset mid-read: deassert i_rstn in BUSY. Expect o_bram_trig=0 and all outputs 0 immediately, without waiting for a clock edge. After release, requester 0 wins a simultaneous request against requester 3.
- Abandoned request: requester 0 drops trig in BUSY. The read completes, and o_req_done[0] still pulses with the BRAM data.
